// File: rtl/frame_sequencer.sv
// Frame timing and index engine for the 7-segment animation player.
// A prescaler produces frame ticks, paused mode takes single steps, and an animation change restarts at frame 0.
module frame_sequencer #(
  parameter int unsigned BASE_DIV = 24'd1_000_000,
  parameter int          CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] anim_sel,
  input  logic       run,
  input  logic       step,
  input  logic [2:0] speed,
  input  logic [4:0] limit,
  output logic [4:0] anim_cur,
  output logic [4:0] frame,
  output logic       tick,
  output logic       frame_wrap
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSE  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  localparam logic [CNT_W:0] BASE_EXT = (CNT_W+1)'(BASE_DIV);
  localparam logic [CNT_W:0] ONE_EXT  = (CNT_W+1)'(1);

  state_t             state_q, state_d;
  logic [4:0]         anim_q, anim_d;
  logic [4:0]         frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               step_q, step_d;

  logic [CNT_W:0]     period_raw;
  logic [CNT_W:0]     period_m1;
  logic               cnt_end;
  logic [4:0]         lim_m1;
  logic               adv;

  // Periods that shift down to 0 or 1 both mean "advance every cycle".
  assign period_raw = BASE_EXT >> speed;
  assign period_m1  = (period_raw > ONE_EXT) ? (period_raw - ONE_EXT) : '0;
  assign cnt_end    = ({1'b0, cnt_q} >= period_m1);
  assign lim_m1     = (limit == 5'd0) ? 5'd0 : (limit - 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      anim_q  <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      anim_q  <= anim_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    anim_d  = anim_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    step_d  = step_q;
    adv     = 1'b0;

    if (ena) begin
      step_d = step;
      if ((state_q != S_SWITCH) && (anim_sel != anim_q)) begin
        state_d = S_SWITCH;
        anim_d  = anim_sel;
        frame_d = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          S_SWITCH: begin
            frame_d = '0;
            cnt_d   = '0;
            state_d = run ? S_RUN : S_PAUSE;
          end
          S_RUN: begin
            // Falling run drops any advance that would land this cycle.
            if (!run) begin
              state_d = S_PAUSE;
              cnt_d   = '0;
            end else if (cnt_end) begin
              adv   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_PAUSE: begin
            cnt_d = '0;
            adv   = step & ~step_q;
            if (run) begin
              state_d = S_RUN;
            end
          end
          default: begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        endcase
      end

      // frame beyond a shrunken limit also wraps to 0.
      if (adv) begin
        tick_d = 1'b1;
        if (frame_q >= lim_m1) begin
          frame_d = '0;
          wrap_d  = 1'b1;
        end else begin
          frame_d = frame_q + 5'd1;
        end
      end
    end
  end

  assign anim_cur   = anim_q;
  assign frame      = frame_q;
  assign tick       = tick_q;
  assign frame_wrap = wrap_q;

endmodule
